data_mem_ctrl: RTL

Initiator-side controller that drives the single-port data RAM (sync write, async read) on behalf of the MIPS core's load/store stage. It converts byte addresses into word indices, performs byte/halfword/word loads with sign or zero extension, and does sub-word stores as read-modify-write. Alignment and range are checked before any RAM access. The block sits between the core LSU request/response handshake and the RAM's data/addr/we/q port.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/lane_align.sv | 50 +++++
 rtl/data_mem_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the default byte address of RAM word 0.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

  // Illegal size counts as misaligned so one term covers every encoding fault.
  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    unique case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian byte-lane steering: extracts and extends load data, and merges
// sub-word store data into the word read from RAM.
module lane_align
  import mem_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh      = {offset, 3'b000};
  assign shifted = word >> sh;
  assign b       = shifted[7:0];
  assign h       = shifted[15:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_data = word;
    merged    = wdata;
    mask      = '0;
    unique case (size)
      SZ_BYTE: begin
        load_data = uns ? {24'h0, b} : {{24{b[7]}}, b};
        mask      = 32'h0000_00FF << sh;
        merged    = (word & ~mask) | ((wdata & 32'h0000_00FF) << sh);
      end
      SZ_HALF: begin
        load_data = uns ? {16'h0, h} : {{16{h[15]}}, h};
        mask      = 32'h0000_FFFF << sh;
        merged    = (word & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller for the single-port data RAM: range/alignment checks,
// sign/zero-extended loads, and read-modify-write for sub-word stores.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          RAM_ADDR_WIDTH = 32,
  parameter int          DEPTH          = 50,
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [DATA_WIDTH-1:0]     ram_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_we,
  input  logic [DATA_WIDTH-1:0]     ram_q
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e                    state, state_nxt;
  logic                      r_we;
  size_e                     r_size;
  logic                      r_uns;
  logic [1:0]                r_off;
  logic [31:0]               r_wdata;
  logic [31:0]               r_index;
  logic [DATA_WIDTH-1:0]     wr_word;
  logic [RAM_ADDR_WIDTH-1:0] addr_hold;

  logic        hs;
  logic        req_err;
  logic [31:0] req_index;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE) && reset;
  assign hs        = req_valid && req_ready;

  // Underflow below BASE_ADDR wraps to a huge index; the explicit compare
  // catches it regardless of what the subtraction produces.
  assign req_index = (req_addr - BASE_ADDR) >> 2;
  assign req_err   = misaligned(size_e'(req_size), req_addr[1:0])
                  || (req_addr < BASE_ADDR)
                  || (req_index >= DEPTH_W);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hs) begin
          if (req_err)                                    state_nxt = RESP;
          else if (req_we && (size_e'(req_size) == SZ_WORD)) state_nxt = WR;
          else                                            state_nxt = RD;
        end
      end
      RD:      state_nxt = r_we ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lane_align u_lane_align (
    .size      (r_size),
    .offset    (r_off),
    .uns       (r_uns),
    .word      (ram_q[31:0]),
    .wdata     (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the RAM array itself is never reset here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
      r_off     <= '0;
      r_wdata   <= '0;
      r_index   <= '0;
      wr_word   <= '0;
      addr_hold <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        r_we      <= req_we;
        r_size    <= size_e'(req_size);
        r_uns     <= req_unsigned;
        r_off     <= req_addr[1:0];
        r_wdata   <= req_wdata;
        r_index   <= req_index;
        rsp_rdata <= '0;
        rsp_err   <= req_err;
        if (req_we && !req_err) wr_word <= DATA_WIDTH'(req_wdata);
      end
      if (state == RD) begin
        if (r_we) wr_word   <= DATA_WIDTH'(merged);
        else      rsp_rdata <= load_data;
      end
      if ((state == RD) || (state == WR)) addr_hold <= ram_addr;
    end
  end

  // Write enable is decoded from state so an async reset drops it at once.
  assign ram_we    = (state == WR);
  assign ram_addr  = ((state == RD) || (state == WR)) ? RAM_ADDR_WIDTH'(r_index) : addr_hold;
  assign ram_data  = wr_word;
  assign rsp_valid = (state == RESP);

endmodule
